// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers pixel coordinates, measures line/frame geometry and locks to an expected mode.
// Optional per-frame pixel CRC is built when VGA_SYNC_DECODER_CRC_EN is defined.
//
// state   | meaning
// SEARCH  | no frame reference yet; first vs_fall only starts measuring
// MEASURE | comparing each completed frame, counting consecutive matches
// LOCKED  | timing matches the expected mode; a mismatch drops back to MEASURE
module vga_sync_decoder #(
  parameter int EXP_H_TOTAL  = 800,
  parameter int EXP_V_TOTAL  = 525,
  parameter int EXP_H_ACTIVE = 640,
  parameter int EXP_V_ACTIVE = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK_n,
  input  logic [3:0]  iVGA_R,
  input  logic [3:0]  iVGA_G,
  input  logic [3:0]  iVGA_B,
  output logic        oPIX_VALID,
  output logic [10:0] oX,
  output logic [9:0]  oY,
  output logic [11:0] oRGB,
  output logic [10:0] oH_TOTAL,
  output logic [9:0]  oV_TOTAL,
  output logic [10:0] oH_ACTIVE,
  output logic [9:0]  oV_ACTIVE,
  output logic        oLOCKED,
  output logic [7:0]  oERR_CNT,
  output logic [15:0] oFRAME_CRC
);

  localparam int          TO_INT       = (2 * EXP_H_TOTAL > 2047) ? 2047 : 2 * EXP_H_TOTAL;
  localparam logic [10:0] LP_TIMEOUT   = 11'(TO_INT);
  localparam logic [10:0] LP_H_TOTAL   = 11'(EXP_H_TOTAL);
  localparam logic [9:0]  LP_V_TOTAL   = 10'(EXP_V_TOTAL);
  localparam logic [10:0] LP_H_ACTIVE  = 11'(EXP_H_ACTIVE);
  localparam logic [9:0]  LP_V_ACTIVE  = 10'(EXP_V_ACTIVE);
  localparam logic [3:0]  LP_LOCK      = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic        r_hs1, r_vs1, r_bl1, r_hs2, r_vs2, r_bl2;
  logic [11:0] r_rgb1;
  logic [10:0] r_col, r_h_cnt;
  logic [9:0]  r_row, r_v_cnt;
  logic        r_to_seen;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_good, w_good_nxt;

  logic        w_hs_fall, w_vs_fall, w_bl_rise, w_bl_fall;
  logic [10:0] w_x_cur, w_h_cnt_inc;
  logic [9:0]  w_row_inc, w_v_cnt_inc, w_v_total_new, w_v_active_new;
  logic        w_timeout, w_match, w_err_inc, w_locked_nxt;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_bl1  <= 1'b0;
      r_rgb1 <= '0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
      r_bl2  <= 1'b0;
    end else begin
      r_hs1  <= iHS;
      r_vs1  <= iVS;
      r_bl1  <= iBLANK_n;
      r_rgb1 <= {iVGA_R, iVGA_G, iVGA_B};
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_bl2  <= r_bl1;
    end
  end

  assign w_hs_fall = r_hs2 & ~r_hs1;
  assign w_vs_fall = r_vs2 & ~r_vs1;
  assign w_bl_rise = ~r_bl2 & r_bl1;
  assign w_bl_fall = r_bl2 & ~r_bl1;

  assign w_x_cur        = w_bl_rise ? 11'd0 : r_col;
  assign w_row_inc      = (r_row == 10'h3FF) ? r_row : r_row + 10'd1;
  assign w_h_cnt_inc    = (r_h_cnt == 11'h7FF) ? r_h_cnt : r_h_cnt + 11'd1;
  assign w_v_cnt_inc    = (r_v_cnt == 10'h3FF) ? r_v_cnt : r_v_cnt + 10'd1;
  // A line or active run ending on the vs_fall cycle still belongs to the closing frame.
  assign w_v_total_new  = w_hs_fall ? w_v_cnt_inc : r_v_cnt;
  assign w_v_active_new = w_bl_fall ? w_row_inc : r_row;
  assign w_timeout      = (r_h_cnt >= LP_TIMEOUT) && !r_to_seen && !w_hs_fall;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      oPIX_VALID <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oRGB       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      oH_ACTIVE  <= '0;
      oV_ACTIVE  <= '0;
    end else begin
      oPIX_VALID <= r_bl1;
      if (r_bl1) begin
        oX    <= w_x_cur;
        oY    <= r_row;
        oRGB  <= r_rgb1;
        r_col <= (w_x_cur == 11'h7FF) ? w_x_cur : w_x_cur + 11'd1;
      end
      if (w_bl_fall) oH_ACTIVE <= r_col;
      if (w_vs_fall) begin
        oV_ACTIVE <= w_v_active_new;
        r_row     <= '0;
      end else if (w_bl_fall) begin
        r_row <= w_row_inc;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_h_cnt   <= '0;
      oH_TOTAL  <= '0;
      r_v_cnt   <= '0;
      oV_TOTAL  <= '0;
      r_to_seen <= 1'b0;
    end else begin
      if (w_hs_fall) begin
        oH_TOTAL <= w_h_cnt_inc;
        r_h_cnt  <= '0;
      end else begin
        r_h_cnt <= w_h_cnt_inc;
      end
      if (w_vs_fall) begin
        oV_TOTAL <= w_v_total_new;
        r_v_cnt  <= '0;
      end else if (w_hs_fall) begin
        r_v_cnt <= w_v_cnt_inc;
      end
      if (w_hs_fall)      r_to_seen <= 1'b0;
      else if (w_timeout) r_to_seen <= 1'b1;
    end
  end

  // H values compared are the registered ones from the closing frame, not this cycle's update.
  assign w_match = (oH_TOTAL == LP_H_TOTAL) && (oH_ACTIVE == LP_H_ACTIVE) &&
                   (w_v_total_new == LP_V_TOTAL) && (w_v_active_new == LP_V_ACTIVE);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state  <= ST_SEARCH;
      r_good   <= '0;
      oLOCKED  <= 1'b0;
      oERR_CNT <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      oLOCKED <= w_locked_nxt;
      if (w_err_inc && (oERR_CNT != 8'hFF)) oERR_CNT <= oERR_CNT + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (w_timeout) begin
      w_state_nxt = ST_SEARCH;
      w_good_nxt  = '0;
    end else if (w_vs_fall) begin
      case (r_state)
        ST_SEARCH: begin
          w_state_nxt = ST_MEASURE;
          w_good_nxt  = '0;
        end
        ST_MEASURE: begin
          if (w_match) begin
            w_good_nxt = r_good + 4'd1;
            if (r_good + 4'd1 >= LP_LOCK) w_state_nxt = ST_LOCKED;
          end else begin
            w_good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_match) begin
            w_state_nxt = ST_MEASURE;
            w_good_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_err_inc = w_timeout;
    if (w_vs_fall && (r_state != ST_SEARCH) && !w_match) w_err_inc = 1'b1;
    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

`ifdef VGA_SYNC_DECODER_CRC_EN
  logic [15:0] r_crc;

  function automatic logic [15:0] f_crc12(input logic [15:0] i_crc, input logic [11:0] i_data);
    logic [15:0] v_crc;
    logic        v_fb;
    v_crc = i_crc;
    for (int i = 11; i >= 0; i--) begin
      v_fb  = v_crc[15] ^ i_data[i];
      v_crc = {v_crc[14:0], 1'b0} ^ (v_fb ? 16'h1021 : 16'h0000);
    end
    return v_crc;
  endfunction

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_crc      <= 16'hFFFF;
      oFRAME_CRC <= '0;
    end else if (w_vs_fall) begin
      oFRAME_CRC <= r_crc;
      r_crc      <= 16'hFFFF;
    end else if (r_bl1) begin
      r_crc <= f_crc12(r_crc, r_rgb1);
    end
  end
`else
  assign oFRAME_CRC = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a reduced video mode to keep runs short.
// Pixels are scoreboarded; lock/error/measurement status is checked at frame boundaries.
module tb_vga_sync_decoder;

  localparam int HT  = 64;
  localparam int HA  = 40;
  localparam int HSW = 8;
  localparam int HS0 = 16;
  localparam int VT  = 30;
  localparam int VA  = 20;
  localparam int VSW = 2;
  localparam int VS0 = 5;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic        iHS = 1'b1, iVS = 1'b1, iBLANK_n = 1'b0;
  logic [3:0]  iVGA_R = '0, iVGA_G = '0, iVGA_B = '0;
  logic        oPIX_VALID, oLOCKED;
  logic [10:0] oX, oH_TOTAL, oH_ACTIVE;
  logic [9:0]  oY, oV_TOTAL, oV_ACTIVE;
  logic [11:0] oRGB;
  logic [7:0]  oERR_CNT;
  logic [15:0] oFRAME_CRC;

  vga_sync_decoder #(
    .EXP_H_TOTAL(HT), .EXP_V_TOTAL(VT), .EXP_H_ACTIVE(HA), .EXP_V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
    .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
    .oPIX_VALID(oPIX_VALID), .oX(oX), .oY(oY), .oRGB(oRGB),
    .oH_TOTAL(oH_TOTAL), .oV_TOTAL(oV_TOTAL), .oH_ACTIVE(oH_ACTIVE), .oV_ACTIVE(oV_ACTIVE),
    .oLOCKED(oLOCKED), .oERR_CNT(oERR_CNT), .oFRAME_CRC(oFRAME_CRC)
  );

  always #5 vga_clk = ~vga_clk;

  int          checks = 0;
  int          errs = 0;
  int unsigned cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] rgb;
    int unsigned cyc;
  } pix_t;

  pix_t        q[$];
  pix_t        mon_e;
  bit          sb_on = 1'b0;
  bit          frame_full = 1'b0;
  bit          crc_chk = 1'b0;
  logic [15:0] crc_acc = 16'hFFFF;
  logic [15:0] crc_exp = 16'h0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Data aligned to the top of the register, then shifted out MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c ^ {d, 4'h0};
    for (int k = 0; k < 12; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always @(negedge vga_clk) begin
    if (oPIX_VALID === 1'b1) begin
      if (q.size() == 0) begin
        if (sb_on) check("pix_unexpected", 64'(oPIX_VALID), 64'(0));
      end else begin
        mon_e = q.pop_front();
        check("pix_xy", 64'({oX, oY}), 64'({mon_e.x, mon_e.y}));
        check("pix_rgb", 64'(oRGB), 64'(mon_e.rgb));
        check("pix_latency", 64'(cyc - mon_e.cyc), 64'(2));
      end
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic bl, input logic [11:0] rgb, input bit rst);
    iHS = hs;
    iVS = vs;
    iBLANK_n = bl;
    {iVGA_R, iVGA_G, iVGA_B} = rgb;
    reset = rst;
    @(posedge vga_clk);
    #1;
    if (rst) begin
      reset = 1'b0;
      q.delete();
      sb_on = 1'b0;
      frame_full = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pix"}, 64'({oPIX_VALID, oX, oY, oRGB}), 64'(0));
    check({tag, "_meas"}, 64'({oH_TOTAL, oV_TOTAL, oH_ACTIVE, oV_ACTIVE}), 64'(0));
    check({tag, "_stat"}, 64'({oLOCKED, oERR_CNT, oFRAME_CRC}), 64'(0));
  endtask

  task automatic run_frame(input int stretch, input int rst_line);
    int          len;
    logic        hs, vs, bl;
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] rgb;
    bit          rst;
    pix_t        p;
    for (int l = 0; l < VT; l++) begin
      len = (l == stretch) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (l == 0 && c == 0) begin
          crc_chk    = frame_full;
          crc_exp    = crc_acc;
          crc_acc    = 16'hFFFF;
          frame_full = 1'b1;
          sb_on      = 1'b1;
        end
        hs  = (c >= HSW);
        vs  = (l >= VSW);
        bl  = (l >= VS0) && (l < VS0 + VA) && (c >= HS0) && (c < HS0 + HA);
        x   = 11'(c - HS0);
        y   = 10'(l - VS0);
        rgb = bl ? {x[3:0], y[3:0], 4'hA} : 12'h000;
        rst = (l == rst_line) && (c == HS0 + 10);
        if (bl && sb_on) begin
          p.x = x; p.y = y; p.rgb = rgb; p.cyc = cyc;
          q.push_back(p);
          crc_acc = crc_step(crc_acc, rgb);
        end
        drive(hs, vs, bl, rgb, rst);
        if (rst) check_zero_outputs("mid_reset");
        if (stretch >= 0 && l == stretch + 1 && c == HS0) check("h_total_stretch", 64'(oH_TOTAL), 64'(HT + 1));
      end
    end
`ifdef VGA_SYNC_DECODER_CRC_EN
    if (crc_chk) check("frame_crc", 64'(oFRAME_CRC), 64'(crc_exp));
`else
    check("frame_crc_off", 64'(oFRAME_CRC), 64'(0));
`endif
  endtask

  task automatic chk_status(input string tag, input logic lk, input int ec);
    check({tag, "_locked"}, 64'(oLOCKED), 64'(lk));
    check({tag, "_err"}, 64'(oERR_CNT), 64'(ec));
  endtask

  task automatic chk_meas(input string tag);
    check({tag, "_meas"}, 64'({oH_TOTAL, oV_TOTAL, oH_ACTIVE, oV_ACTIVE}),
          64'({11'(HT), 10'(VT), 11'(HA), 10'(VA)}));
  endtask

  initial begin
    repeat (3) @(posedge vga_clk);
    #1;
    check_zero_outputs("reset_state");
    reset = 1'b0;
    sb_on = 1'b1;
    frame_full = 1'b1;
    repeat (4) drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);

    run_frame(-1, -1); chk_status("f1", 1'b0, 0);
    run_frame(-1, -1); chk_status("f2", 1'b0, 0); chk_meas("f2");
    run_frame(-1, -1); chk_status("f3", 1'b1, 0); chk_meas("f3");
    run_frame(-1, -1); chk_status("f4", 1'b1, 0); chk_meas("f4");

    run_frame(VT - 2, -1); chk_status("f5_stretch", 1'b1, 0);
    run_frame(-1, -1); chk_status("f6", 1'b0, 1); chk_meas("f6");
    run_frame(-1, -1); chk_status("f7", 1'b0, 1);
    run_frame(-1, -1); chk_status("f8_relock", 1'b1, 1);

    repeat (200) drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    chk_status("timeout", 1'b0, 2);
    run_frame(-1, -1); chk_status("f9", 1'b0, 2);
    run_frame(-1, -1); chk_status("f10", 1'b0, 2);
    run_frame(-1, -1); chk_status("f11_relock", 1'b1, 2); chk_meas("f11");

    run_frame(-1, 10); chk_status("f12_reset", 1'b0, 0);
    run_frame(-1, -1); chk_status("f13", 1'b0, 0);
    run_frame(-1, -1); chk_status("f14", 1'b0, 0);
    run_frame(-1, -1); chk_status("f15_relock", 1'b1, 0); chk_meas("f15");

    repeat (8) drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    check("pix_drain", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
